// File: rtl/prime_detect_ctrl_if.sv
// Request/response channel between the prime-detector controller and the detector core.
// The master side issues operands and accepts 1-bit results.
interface prime_detect_ctrl_if #(
  parameter int unsigned nbits = 32
);
  logic             det_req_val;
  logic             det_req_rdy;
  logic [nbits-1:0] det_req_msg;
  logic             det_resp_val;
  logic             det_resp_rdy;
  logic             det_resp_msg;

  modport master (
    output det_req_val,
    output det_req_msg,
    output det_resp_rdy,
    input  det_req_rdy,
    input  det_resp_val,
    input  det_resp_msg
  );

  modport slave (
    input  det_req_val,
    input  det_req_msg,
    input  det_resp_rdy,
    output det_req_rdy,
    output det_resp_val,
    output det_resp_msg
  );
endinterface

// File: rtl/prime_detect_ctrl.sv
// Sequencing controller for the prime detector: assembles an operand from pin-strobed chunks,
// issues it over a val/rdy request, and holds the returned 1-bit verdict on status outputs.
module prime_detect_ctrl #(
  parameter int unsigned nbits = 32,
  parameter int unsigned chunk = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [chunk-1:0]                in_chunk,
  input  logic                            in_load,
  prime_detect_ctrl_if.master             det,
  output logic                            busy,
  output logic                            done,
  output logic                            is_prime,
  output logic [$clog2(nbits/chunk):0]    chunk_count
);

  localparam int unsigned NumChunks = nbits / chunk;
  localparam int unsigned CntW      = $clog2(NumChunks) + 1;
  localparam logic [CntW-1:0] CntFull = CntW'(NumChunks);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  typedef enum logic [1:0] {StLoad, StReq, StWait, StDone} state_e;

  state_e           state_q, state_d;
  logic [nbits-1:0] operand_q, operand_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             load_prev_q;
  logic             is_prime_q, is_prime_d;
  logic             req_val_q, req_val_d;
  logic             resp_rdy_q, resp_rdy_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             load_evt;
  logic [CntW-1:0]  cnt_inc;
  logic [nbits-1:0] chunk_ext;

  // load_prev resets high so a strobe already asserted through reset is not a load.
  assign load_evt  = in_load & ~load_prev_q;
  assign cnt_inc   = cnt_q + CntOne;
  assign chunk_ext = nbits'(in_chunk);

  always_comb begin
    state_d    = state_q;
    operand_d  = operand_q;
    cnt_d      = cnt_q;
    is_prime_d = is_prime_q;

    unique case (state_q)
      StLoad: begin
        if (load_evt) begin
          operand_d = (operand_q << chunk) | chunk_ext;
          cnt_d     = cnt_inc;
          if (cnt_inc == CntFull) begin
            state_d = StReq;
          end
        end
      end
      StReq: begin
        // req_val is registered high throughout StReq, so rdy alone completes the handshake.
        if (det.det_req_rdy) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (det.det_resp_val) begin
          is_prime_d = det.det_resp_msg;
          state_d    = StDone;
        end
      end
      StDone: begin
        if (load_evt) begin
          operand_d  = chunk_ext;
          cnt_d      = CntOne;
          is_prime_d = 1'b0;
          state_d    = (CntOne == CntFull) ? StReq : StLoad;
        end
      end
      default: begin
        state_d = StLoad;
      end
    endcase

    // Outputs are registered copies of the next-state decode.
    req_val_d  = (state_d == StReq);
    resp_rdy_d = (state_d == StWait);
    busy_d     = (state_d == StReq) || (state_d == StWait);
    done_d     = (state_d == StDone);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StLoad;
      operand_q   <= '0;
      cnt_q       <= '0;
      load_prev_q <= 1'b1;
      is_prime_q  <= 1'b0;
      req_val_q   <= 1'b0;
      resp_rdy_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      operand_q   <= operand_d;
      cnt_q       <= cnt_d;
      load_prev_q <= in_load;
      is_prime_q  <= is_prime_d;
      req_val_q   <= req_val_d;
      resp_rdy_q  <= resp_rdy_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign det.det_req_val  = req_val_q;
  assign det.det_req_msg  = operand_q;
  assign det.det_resp_rdy = resp_rdy_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign is_prime         = is_prime_q;
  assign chunk_count      = cnt_q;

endmodule

// File: tb/tb_prime_detect_ctrl.sv
// Directed bench for prime_detect_ctrl; the detector side is driven by hand from the stimulus.
module tb_prime_detect_ctrl;

  localparam int unsigned NBits = 32;
  localparam int unsigned Chunk = 4;

  logic       clk;
  logic       reset;
  logic [3:0] in_chunk;
  logic       in_load;
  logic       busy;
  logic       done;
  logic       is_prime;
  logic [3:0] chunk_count;

  int checks = 0;
  int errors = 0;

  prime_detect_ctrl_if #(.nbits(NBits)) det_if ();

  prime_detect_ctrl #(
    .nbits(NBits),
    .chunk(Chunk)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_chunk   (in_chunk),
    .in_load    (in_load),
    .det        (det_if),
    .busy       (busy),
    .done       (done),
    .is_prime   (is_prime),
    .chunk_count(chunk_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    in_load = 1'b0;
    reset   = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  // Loads a full word MSB-first; returns right after the edge that takes the last chunk.
  task automatic load_word(input logic [31:0] w);
    for (int i = 7; i >= 0; i--) begin
      in_chunk = w[i*4 +: 4];
      in_load  = 1'b1;
      tick();
      in_load = 1'b0;
      if (i > 0) tick();
    end
  endtask

  initial begin
    reset                  = 1'b1;
    in_chunk               = 4'h0;
    in_load                = 1'b1;
    det_if.det_req_rdy     = 1'b0;
    det_if.det_resp_val    = 1'b0;
    det_if.det_resp_msg    = 1'b0;

    // Strobe held high through reset and beyond must not load.
    tick();
    tick();
    reset = 1'b0;
    tick();
    tick();
    tick();
    check("rst_count", 32'(chunk_count), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_prime", 32'(is_prime), 32'd0);
    check("rst_req_val", 32'(det_if.det_req_val), 32'd0);
    check("rst_resp_rdy", 32'(det_if.det_resp_rdy), 32'd0);
    check("rst_msg", det_if.det_req_msg, 32'h0);
    in_load = 1'b0;
    tick();

    // Operand 7, detector says prime.
    load_word(32'h0000_0007);
    check("w7_req_val", 32'(det_if.det_req_val), 32'd1);
    check("w7_msg", det_if.det_req_msg, 32'h0000_0007);
    check("w7_count", 32'(chunk_count), 32'd8);
    check("w7_busy", 32'(busy), 32'd1);
    det_if.det_req_rdy = 1'b1;
    tick();
    det_if.det_req_rdy = 1'b0;
    check("w7_wait_req_val", 32'(det_if.det_req_val), 32'd0);
    check("w7_wait_resp_rdy", 32'(det_if.det_resp_rdy), 32'd1);
    det_if.det_resp_val = 1'b1;
    det_if.det_resp_msg = 1'b1;
    tick();
    det_if.det_resp_val = 1'b0;
    check("w7_done", 32'(done), 32'd1);
    check("w7_busy_low", 32'(busy), 32'd0);
    check("w7_prime", 32'(is_prime), 32'd1);
    check("w7_count_hold", 32'(chunk_count), 32'd8);

    // Response outside WAIT is ignored.
    det_if.det_resp_val = 1'b1;
    det_if.det_resp_msg = 1'b0;
    tick();
    det_if.det_resp_val = 1'b0;
    check("stray_resp_prime", 32'(is_prime), 32'd1);
    check("stray_resp_done", 32'(done), 32'd1);
    tick();

    // Operand 0xF, detector says not prime; then one new nibble restarts from DONE.
    load_word(32'h0000_000F);
    check("wf_msg", det_if.det_req_msg, 32'h0000_000F);
    det_if.det_req_rdy = 1'b1;
    tick();
    det_if.det_req_rdy  = 1'b0;
    det_if.det_resp_val = 1'b1;
    det_if.det_resp_msg = 1'b0;
    tick();
    det_if.det_resp_val = 1'b0;
    check("wf_done", 32'(done), 32'd1);
    check("wf_prime", 32'(is_prime), 32'd0);
    in_chunk = 4'h3;
    in_load  = 1'b1;
    tick();
    in_load = 1'b0;
    check("restart_done", 32'(done), 32'd0);
    check("restart_count", 32'(chunk_count), 32'd1);
    check("restart_operand", det_if.det_req_msg, 32'h0000_0003);
    check("restart_busy", 32'(busy), 32'd0);
    tick();

    do_reset();
    check("lrst_count", 32'(chunk_count), 32'd0);

    // Backpressure: request must hold steady while rdy is low.
    load_word(32'h0001_FFFF);
    for (int i = 0; i < 5; i++) begin
      check("bp_req_val", 32'(det_if.det_req_val), 32'd1);
      check("bp_msg", det_if.det_req_msg, 32'h0001_FFFF);
      tick();
    end
    det_if.det_req_rdy = 1'b1;
    tick();
    check("bp_hs_req_val", 32'(det_if.det_req_val), 32'd0);
    check("bp_hs_resp_rdy", 32'(det_if.det_resp_rdy), 32'd1);
    tick();
    det_if.det_req_rdy = 1'b0;
    check("bp_single_hs", 32'(det_if.det_req_val), 32'd0);
    check("bp_still_wait", 32'(det_if.det_resp_rdy), 32'd1);

    // Load strobes during WAIT are ignored.
    for (int i = 0; i < 4; i++) begin
      in_chunk = 4'hA;
      in_load  = 1'b1;
      tick();
      in_load = 1'b0;
      tick();
    end
    check("wait_ld_count", 32'(chunk_count), 32'd8);
    check("wait_ld_operand", det_if.det_req_msg, 32'h0001_FFFF);
    check("wait_ld_busy", 32'(busy), 32'd1);
    check("wait_ld_done", 32'(done), 32'd0);
    det_if.det_resp_val = 1'b1;
    det_if.det_resp_msg = 1'b1;
    tick();
    det_if.det_resp_val = 1'b0;
    check("wait_ld_fin_done", 32'(done), 32'd1);
    check("wait_ld_fin_prime", 32'(is_prime), 32'd1);
    tick();

    // Reset during WAIT abandons the transaction.
    load_word(32'h1234_5678);
    det_if.det_req_rdy = 1'b1;
    tick();
    det_if.det_req_rdy = 1'b0;
    check("w2_in_wait", 32'(det_if.det_resp_rdy), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_count", 32'(chunk_count), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_resp_rdy", 32'(det_if.det_resp_rdy), 32'd0);
    check("async_rst_msg", det_if.det_req_msg, 32'h0);
    tick();
    reset = 1'b0;
    tick();
    load_word(32'hCAFE_0123);
    check("post_rst_req_val", 32'(det_if.det_req_val), 32'd1);
    check("post_rst_msg", det_if.det_req_msg, 32'hCAFE_0123);
    check("post_rst_count", 32'(chunk_count), 32'd8);
    det_if.det_req_rdy = 1'b1;
    tick();
    det_if.det_req_rdy  = 1'b0;
    det_if.det_resp_val = 1'b1;
    det_if.det_resp_msg = 1'b0;
    tick();
    det_if.det_resp_val = 1'b0;
    check("post_rst_done", 32'(done), 32'd1);
    check("post_rst_prime", 32'(is_prime), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prime_detect_ctrl.md
Name: prime_detect_ctrl

Overview:
Sequencing controller for the prime-detector datapath. It assembles an nbits operand from chunk-wide pieces strobed in on a pin-level load input, issues the operand to the detector core over a val/rdy request interface, and accepts the 1-bit result over a val/rdy response interface. It holds the result on status outputs for the top-level io_out mapping.

Parameters:
- nbits, 32, operand width sent to the detector; must be a multiple of chunk.
- chunk, 4, bits accepted per load strobe; 1 <= chunk <= nbits.

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- reset, input, 1, asynchronous, active-high reset.
- in_chunk, input, chunk, next operand piece, MSB-first order.
- in_load, input, 1, level load strobe from the pin; a rising edge loads one chunk.
- det_req_val, output, 1, request valid to the detector.
- det_req_rdy, input, 1, detector ready for a request.
- det_req_msg, output, nbits, operand to test.
- det_resp_val, input, 1, detector result valid.
- det_resp_rdy, output, 1, controller ready for the result.
- det_resp_msg, input, 1, 1 = prime.
- busy, output, 1, high in REQ or WAIT.
- done, output, 1, high in DONE.
- is_prime, output, 1, captured result; meaningful only while done=1.
- chunk_count, output, $clog2(nbits/chunk)+1, number of chunks loaded for the current operand.

Behaviour:
- Reset (async, any state): state=LOAD, operand=0, chunk_count=0, is_prime=0, load_prev=1, and all outputs 0. Because load_prev resets to 1, an in_load held high through reset is not a load.
- Load event: in_load=1 and load_prev=0 in the same cycle. load_prev <= in_load every cycle. A strobe held high for many cycles counts as exactly one load.
- LOAD state:
  - On a load event, operand <= {operand[nbits-chunk-1:0], in_chunk} and chunk_count++.
  - If this load makes chunk_count == nbits/chunk, the same edge moves state to REQ. det_req_val rises in the following cycle.
- REQ state:
  - det_req_val=1 and det_req_msg=operand, held stable until the handshake.
  - When det_req_val && det_req_rdy, the next state is WAIT.
  - det_resp_rdy=0.
- WAIT state:
  - det_resp_rdy=1 and det_req_val=0.
  - When det_resp_val, is_prime <= det_resp_msg and state moves to DONE. done is high in the next cycle, giving 1-cycle latency from response acceptance.
- DONE state:
  - done=1, is_prime valid, chunk_count stays at nbits/chunk.
  - A load event here starts a new operand on the same edge: operand <= {zeros, in_chunk}, chunk_count=1, is_prime=0, state=LOAD.
- Load events in REQ or WAIT are ignored; operand and chunk_count are unchanged. load_prev still tracks in_load.
- A det_resp_val arriving outside WAIT is not accepted (det_resp_rdy=0) and has no effect.
- det_req_msg shows the operand register in every state. Only the REQ-state value is architecturally meaningful.
- nbits == chunk: a single load event moves LOAD to REQ.
- Reset asserted in REQ or WAIT: immediate return to LOAD. Any in-flight detector transaction is abandoned; the detector must share the same reset.

Test Plan:
- Reset with in_load held high, then release and keep in_load high 3 cycles -> chunk_count stays 0 and no load occurs; all outputs 0.
- Load nibbles 0,0,0,0,0,0,0,7 with one rising edge each; stub detector det_req_rdy=1, det_resp_val=1 and msg=1 one cycle later -> det_req_val asserts 1 cycle after the 8th edge with msg=0x00000007; then busy falls, done=1, is_prime=1.
- Load 0x0000000F; detector returns 0 -> done=1, is_prime=0. Then load one nibble 0x3 -> done=0, chunk_count=1, internal operand=0x00000003.
- Backpressure: det_req_rdy held 0 for 5 cycles after the operand 0x0001FFFF completes -> det_req_val=1 and det_req_msg=0x0001FFFF stable all 5 cycles; exactly one handshake when rdy rises.
- Toggle in_load 4 times during WAIT, then return det_resp_msg=1 -> chunk_count unchanged at 8, operand unchanged, done=1 afterwards.
- Assert reset during WAIT, deassert, and load a full new operand -> state restarts at LOAD, chunk_count=0 immediately, and the next request carries only the new operand.
